// File: rtl/iter_divider_if.sv
// iter_divider_if: handshake and result bundle between the EXE stage and the iterative divider
// master: drives div_start, div_signed, dividend, divisor, flush; receives DIV_Busy, div_done, quotient, remainder
// slave : the divider side of the same signals
interface iter_divider_if #(
    parameter int WIDTH = 32
);
    logic             div_start;
    logic             div_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             DIV_Busy;
    logic             div_done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    modport master (
        output div_start, div_signed, dividend, divisor, flush,
        input  DIV_Busy, div_done, quotient, remainder
    );
    modport slave (
        input  div_start, div_signed, dividend, divisor, flush,
        output DIV_Busy, div_done, quotient, remainder
    );
endinterface

// File: rtl/iter_divider.sv
// iter_divider: radix-2 restoring DIV/DIVU unit, one bit per cycle, results for LO (quotient) and HI (remainder)
// clk, rst : rising-edge clock, synchronous active-high reset
// bus      : iter_divider_if slave (div_start/div_signed/dividend/divisor/flush in; DIV_Busy/div_done/quotient/remainder out)
module iter_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          rst,
    iter_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs, dvd_raw;
    logic             q_neg, r_neg, div_zero;
    logic             a_neg, b_neg, ge;
    logic [WIDTH-1:0] a_abs, b_abs, rem_nx, quo_nx;
    logic [WIDTH:0]   shifted, diff;
    assign a_neg   = bus.div_signed & bus.dividend[WIDTH-1];
    assign b_neg   = bus.div_signed & bus.divisor[WIDTH-1];
    assign a_abs   = a_neg ? -bus.dividend : bus.dividend;
    assign b_abs   = b_neg ? -bus.divisor : bus.divisor;
    // quo starts as the dividend magnitude; its MSB feeds the partial remainder each step
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign ge      = ~diff[WIDTH];
    assign rem_nx  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_nx  = {quo[WIDTH-2:0], ge};
    assign bus.DIV_Busy = (state != IDLE);
    assign bus.div_done = (state == DONE);
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            rem           <= '0;
            quo           <= '0;
            dvs           <= '0;
            dvd_raw       <= '0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            div_zero      <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.div_start) begin
                    state    <= RUN;
                    cnt      <= CNT_W'(WIDTH);
                    rem      <= '0;
                    quo      <= a_abs;
                    dvs      <= b_abs;
                    dvd_raw  <= bus.dividend;
                    q_neg    <= a_neg ^ b_neg;
                    r_neg    <= a_neg;
                    div_zero <= (bus.divisor == '0);
                end
                RUN: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state         <= DONE;
                        bus.quotient  <= div_zero ? '1 : (q_neg ? -quo_nx : quo_nx);
                        bus.remainder <= div_zero ? dvd_raw : (r_neg ? -rem_nx : rem_nx);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
